// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: round-robin owner selection for one shared I2C bus.
// A grant watchdog sets a sticky per-client flag and masks the offender.
// A guaranteed SCL-high gap separates owners.
// Only the granted client's pull-downs reach the pad.
module i2c_bus_arbiter #(
    parameter int N_CLIENTS      = 2,
    parameter int GAP_CYCLES     = 64,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int OWNER_W        = 4
) (
    input  logic                 ipClk,
    input  logic                 ipReset,
    input  logic [N_CLIENTS-1:0] ipRequest,
    output logic [N_CLIENTS-1:0] opGrant,
    input  logic [N_CLIENTS-1:0] ipClientSClk,
    input  logic [N_CLIENTS-1:0] ipClientData,
    output logic                 opI2C_SClk,
    output logic                 opI2C_Data,
    input  logic                 ipI2C_SClk,
    output logic [OWNER_W-1:0]   opOwner,
    output logic                 opBusy,
    output logic [N_CLIENTS-1:0] opTimeout,
    input  logic [N_CLIENTS-1:0] ipClearTimeout
);

    // Counters only ever need to reach their terminal value (LIMIT-1) and then saturate.
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    localparam logic [N_CLIENTS-1:0] ONE    = N_CLIENTS'(1);
    localparam logic [TW-1:0]        T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0]        G_LAST = GW'(GAP_CYCLES - 1);

    logic [1:0]           r_state;
    logic [N_CLIENTS-1:0] r_grant;
    logic [OWNER_W-1:0]   r_owner;
    logic [OWNER_W-1:0]   r_ptr;
    logic [N_CLIENTS-1:0] r_mask;
    logic [N_CLIENTS-1:0] r_timeout;
    logic [TW-1:0]        r_wdog;
    logic [GW-1:0]        r_gap;
    logic                 r_scl;
    logic                 r_sda;

    logic [1:0]           w_state_nxt;
    logic [N_CLIENTS-1:0] w_grant_nxt;
    logic [OWNER_W-1:0]   w_owner_nxt;
    logic [OWNER_W-1:0]   w_ptr_nxt;
    logic [TW-1:0]        w_wdog_nxt;
    logic [GW-1:0]        w_gap_nxt;
    logic [N_CLIENTS-1:0] w_to_set;
    logic [N_CLIENTS-1:0] w_elig;
    logic                 w_any;
    logic [OWNER_W-1:0]   w_sel;
    logic                 w_req_own;
    logic                 w_scl_nxt;
    logic                 w_sda_nxt;

    // Select bit i of a client vector without a narrow-index part-select.
    function automatic logic f_bit(input logic [N_CLIENTS-1:0] v, input logic [OWNER_W-1:0] i);
        return |(v & (ONE << i));
    endfunction

    // First eligible client searching upward from ptr+1, wrapping around.
    function automatic logic [OWNER_W-1:0] f_pick(input logic [N_CLIENTS-1:0] elig,
                                                  input logic [OWNER_W-1:0]   ptr);
        logic [OWNER_W-1:0] sel;
        logic               found;
        int                 idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 1; k <= N_CLIENTS; k++) begin
            idx = (int'(ptr) + k) % N_CLIENTS;
            if (!found && ((elig & (ONE << idx)) != '0)) begin
                sel   = OWNER_W'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [TW-1:0] f_sat_inc_t(input logic [TW-1:0] v);
        return (v == {TW{1'b1}}) ? v : v + TW'(1);
    endfunction

    function automatic logic [GW-1:0] f_sat_inc_g(input logic [GW-1:0] v);
        return (v == {GW{1'b1}}) ? v : v + GW'(1);
    endfunction

    assign w_elig    = ipRequest & ~r_mask;
    assign w_any     = |w_elig;
    assign w_sel     = f_pick(w_elig, r_ptr);
    assign w_req_own = f_bit(ipRequest, r_owner);

    // Next-state, grant, watchdog and gap-counter decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_wdog_nxt  = r_wdog;
        w_gap_nxt   = r_gap;
        w_to_set    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_grant_nxt = ONE << w_sel;
                    w_owner_nxt = w_sel;
                    w_ptr_nxt   = w_sel;
                    w_wdog_nxt  = '0;
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                // A request drop on the same cycle as expiry is a clean release.
                if (!w_req_own) begin
                    w_grant_nxt = '0;
                    w_gap_nxt   = '0;
                    w_state_nxt = S_GAP;
                end else if ((TIMEOUT_CYCLES != 0) && (r_wdog == T_LAST)) begin
                    w_grant_nxt = '0;
                    w_to_set    = ONE << r_owner;
                    w_gap_nxt   = '0;
                    w_state_nxt = S_GAP;
                end else begin
                    w_wdog_nxt  = f_sat_inc_t(r_wdog);
                end
            end
            S_GAP: begin
                // Any low SCL (stretching, stuck slave) restarts the quiet period.
                if (!ipI2C_SClk) begin
                    w_gap_nxt = '0;
                end else if (r_gap == G_LAST) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_nxt = f_sat_inc_g(r_gap);
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Gate against the next grant so the pad is released on the revoke edge itself.
    assign w_scl_nxt = f_bit(ipClientSClk, w_owner_nxt) & f_bit(w_grant_nxt, w_owner_nxt);
    assign w_sda_nxt = f_bit(ipClientData, w_owner_nxt) & f_bit(w_grant_nxt, w_owner_nxt);

    // State, grant, flags and registered pad drives.
    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_owner   <= '0;
            r_ptr     <= OWNER_W'(N_CLIENTS - 1);
            r_mask    <= '0;
            r_timeout <= '0;
            r_wdog    <= '0;
            r_gap     <= '0;
            r_scl     <= 1'b0;
            r_sda     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_owner   <= w_owner_nxt;
            r_ptr     <= w_ptr_nxt;
            r_mask    <= (r_mask & ipRequest) | w_to_set;
            r_timeout <= (r_timeout & ~ipClearTimeout) | w_to_set;
            r_wdog    <= w_wdog_nxt;
            r_gap     <= w_gap_nxt;
            r_scl     <= w_scl_nxt;
            r_sda     <= w_sda_nxt;
        end
    end

    assign opGrant    = r_grant;
    assign opOwner    = r_owner;
    assign opBusy     = (r_state != S_IDLE);
    assign opTimeout  = r_timeout;
    assign opI2C_SClk = r_scl;
    assign opI2C_Data = r_sda;

endmodule
